// File: rtl/qkv_stream_reader.sv
// Streams NUM_WORDS consecutive words of the Q/K/V matrix out of a fixed-latency memory bar
// onto a valid/ready stream, throttling reads so the return buffer can never overflow.
module qkv_stream_reader #(
    parameter int WIDTH        = 64,
    parameter int BASE_ADDR    = 2048,
    parameter int NUM_WORDS    = 512,
    parameter int READ_LATENCY = 7,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             write_en_bar,
    output logic [WIDTH-1:0] data_in_bar,
    output logic [31:0]      addr_bar,
    input  logic [WIDTH-1:0] data_out_bar,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        beat_cnt;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [READ_LATENCY-1:0] issue_vec;
    logic [INF_W-1:0]        inflight;
    logic [WIDTH-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [OCC_W-1:0]        occ;

    logic issue, push, pop, room, accept, last_issue, last_beat, done_next;

    assign write_en_bar = 1'b0;
    assign data_in_bar  = '0;

    assign accept     = (state == S_IDLE) && start;
    assign push       = rd_pipe[0];
    assign m_valid    = (occ != '0);
    assign pop        = m_valid && m_ready;
    assign last_issue = (issue_cnt == CNT_W'(NUM_WORDS - 1));
    assign last_beat  = (beat_cnt == CNT_W'(NUM_WORDS - 1));
    assign room       = (32'(inflight) + 32'(occ)) < 32'(FIFO_DEPTH);
    assign busy       = (state != S_IDLE);
    assign m_last     = m_valid && last_beat;
    assign m_data     = m_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        issue_vec  = '0;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN: begin
                issue = room;
                if (room && last_issue) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && last_beat) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        issue_vec[READ_LATENCY-1] = issue;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_bar  <= 32'(BASE_ADDR);
            issue_cnt <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_next;
            if (accept) begin
                addr_bar  <= 32'(BASE_ADDR);
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (!last_issue) addr_bar <= addr_bar + 32'd1;
                end
                if (pop) beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Each issued read enters at the top and reaches bit 0 exactly when its data is on the bar.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe  <= '0;
            inflight <= '0;
        end else begin
            rd_pipe <= (rd_pipe >> 1) | issue_vec;
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the buffer storage has no reset; entries are only visible once occ says they were written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= data_out_bar;
    end

endmodule

// File: tb/tb_qkv_stream_reader.sv
// Randomized self-checking bench: a latency-accurate memory model feeds the reader and a
// scoreboard checks every beat against the expected word sequence and done timing.
module tb_qkv_stream_reader;

    localparam int WIDTH = 64;
    localparam int BASE  = 2048;
    localparam int NUM   = 512;
    localparam int LAT   = 7;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n, start, m_ready;
    logic             busy, done, write_en_bar, m_valid, m_last;
    logic [WIDTH-1:0] data_in_bar, data_out_bar, m_data;
    logic [31:0]      addr_bar;

    qkv_stream_reader #(
        .WIDTH(WIDTH), .BASE_ADDR(BASE), .NUM_WORDS(NUM),
        .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .write_en_bar(write_en_bar), .data_in_bar(data_in_bar), .addr_bar(addr_bar),
        .data_out_bar(data_out_bar), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: word BASE+i holds {salt, i}; data appears LAT cycles after the address.
    logic [31:0] salt = 32'd0;
    logic [31:0] apipe [LAT];

    function automatic logic [63:0] word_of(input logic [31:0] a);
        if (a >= 32'(BASE) && a < 32'(BASE + NUM)) return {salt, a - 32'(BASE)};
        return {32'hBADBAD00, a};
    endfunction

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) apipe[i] <= apipe[i-1];
        apipe[0] <= addr_bar;
    end
    assign data_out_bar = word_of(apipe[LAT-1]);

    // Scoreboard: beat k of a transfer must be {salt, k}, last only on k = NUM-1.
    int         clear_req = 0;
    int         clear_seen = 0;
    int         exp_idx = 0;
    int         first_valid_cyc = -1;
    int         last_hs_cyc = -10;
    int         ready_mode = 2;
    bit         stall_prev = 0;
    logic [63:0] held_data;
    logic        held_last;

    always @(negedge clk) begin
        if (clear_seen != clear_req) begin
            clear_seen      = clear_req;
            exp_idx         = 0;
            first_valid_cyc = -1;
        end
        if (rst_n) begin
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, held_data);
                check("hold_last", m_last, held_last);
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (ready_mode == 0 && exp_idx > 0 && exp_idx < NUM) check("no_bubble", m_valid, 1);
            if (done || cyc == last_hs_cyc + 1) check("done_pulse", done, cyc == last_hs_cyc + 1);
            if (m_valid && m_ready) begin
                check("beat_data", m_data, {salt, 32'(exp_idx)});
                check("beat_last", m_last, exp_idx == NUM - 1);
                if (exp_idx == NUM - 1) last_hs_cyc = cyc;
                exp_idx++;
            end
            stall_prev = m_valid && !m_ready;
            held_data  = m_data;
            held_last  = m_last;
        end else begin
            stall_prev = 0;
        end
    end

    int t0 = 0;
    int done_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom % 2);
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic pulse_start();
        clear_req++;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) begin
                seen     = 1;
                done_cyc = cyc;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_addr"}, addr_bar, BASE);
        check({tag, "_wen"}, write_en_bar, 0);
        check({tag, "_wdata"}, data_in_bar, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        m_ready = 1'b0;

        // Reset with start held high must leave everything idle.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        start = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", m_valid, 0);

        // Full-rate transfer: latency and done timing.
        ready_mode = 0;
        salt = 32'd0;
        tick();
        pulse_start();
        repeat (100) tick();
        check("t1_busy", busy, 1);
        wait_done(700);
        check("t1_first_lat", first_valid_cyc - t0, LAT + 2);
        check("t1_done_lat", done_cyc - t0, NUM + LAT + 2);
        check("t1_busy_done", busy, 0);
        check("t1_beats", exp_idx, NUM);

        // Back-pressure for 100 cycles: the reader stops after DEPTH reads.
        ready_mode = 2;
        tick();
        pulse_start();
        repeat (99) tick();
        check("t2_valid", m_valid, 1);
        check("t2_data", m_data, 0);
        check("t2_addr", addr_bar, BASE + DEPTH);
        check("t2_beats", exp_idx, 0);
        ready_mode = 0;
        wait_done(800);
        check("t2_beats_end", exp_idx, NUM);

        // Random back-pressure.
        ready_mode = 1;
        salt = $urandom;
        tick();
        pulse_start();
        wait_done(3000);
        check("t3_beats", exp_idx, NUM);

        // Start pulses during RUN and DRAIN are ignored; start in the done cycle restarts.
        salt = $urandom;
        tick();
        pulse_start();
        repeat (40) tick();
        check("t4_busy_run", busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 3000 && !hit; i++) begin
                tick();
                hit = (addr_bar == BASE + NUM - 1);
            end
            if (!hit) check("t4_addr_timeout", 0, 1);
        end
        tick();
        if (busy) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(3000);
        check("t4_beats_a", exp_idx, NUM);
        pulse_start();
        check("t4_restart_addr", addr_bar, BASE);
        check("t4_restart_busy", busy, 1);
        wait_done(3000);
        check("t4_beats_b", exp_idx, NUM);

        // Reset in the middle of a transfer, then a clean restart.
        ready_mode = 0;
        salt = $urandom;
        tick();
        pulse_start();
        begin
            int n = 0;
            while (exp_idx <= 200 && n < 500) begin
                tick();
                n++;
            end
            if (exp_idx <= 200) check("t5_wait_timeout", 0, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        clear_req++;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("t5_idle", busy, 0);
        check("t5_valid", m_valid, 0);
        pulse_start();
        wait_done(700);
        check("t5_first_lat", first_valid_cyc - t0, LAT + 2);
        check("t5_done_lat", done_cyc - t0, NUM + LAT + 2);
        check("t5_beats", exp_idx, NUM);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
